// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int ADDR_W = 13;
   localparam logic [ADDR_W-1:0] RESET_PC = 13'h1000;
   localparam logic [ADDR_W-1:0] EXC_VEC  = 13'h0180;
   localparam logic [ADDR_W-1:0] PC_INC   = 13'd4;

   typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} fetch_state_t;

   // Winning control event for the current cycle, after priority resolution.
   typedef enum logic [2:0] {EV_NONE, EV_EXC, EV_ERET, EV_REDIR, EV_HALT} ctrl_evt_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux and control-event priority encoder: exc > eret > redirect > halt > sequential.
module pc_next_sel import fetch_pkg::*; (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] epc,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              evt_en,
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic              redirect_valid,
   input  logic              halt_req,
   input  logic              seq_adv,
   output ctrl_evt_t         evt,
   output logic [ADDR_W-1:0] pc_next,
   output logic              misalign
);

   always_comb begin
      // NOTE: every output gets a default first, so no path through the block infers a latch.
      evt      = EV_NONE;
      pc_next  = pc;
      misalign = 1'b0;
      if (evt_en) begin
         if (exc_req) begin
            evt     = EV_EXC;
            pc_next = EXC_VEC;
         end else if (eret_req) begin
            evt     = EV_ERET;
            pc_next = epc;
         end else if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
               // A misaligned target becomes an exception entry.
               evt      = EV_EXC;
               pc_next  = EXC_VEC;
               misalign = 1'b1;
            end else begin
               evt     = EV_REDIR;
               pc_next = redirect_pc;
            end
         end else if (halt_req) begin
            evt = EV_HALT;
         end else if (seq_adv) begin
            pc_next = pc + PC_INC;
         end
      end
   end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures IM words into IR and hands them to decode.
module im_fetch_ctrl import fetch_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [31:0]       im_dout,
   output logic [31:0]       ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic              halt_req,
   output logic [ADDR_W-1:0] epc,
   output logic              fetch_err,
   output logic              busy_exc
);

   fetch_state_t      state, state_nxt;
   ctrl_evt_t         evt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              ir_free, load, misalign;

   assign im_addr = pc;
   assign ir_free = !ir_valid || ir_ready;
   assign load    = (state == RUN) && ir_free;

   pc_next_sel u_pc_next_sel (
      .pc             (pc),
      .epc            (epc),
      .redirect_pc    (redirect_pc),
      .evt_en         (state != BOOT),
      .exc_req        (exc_req),
      .eret_req       (eret_req),
      .redirect_valid (redirect_valid),
      .halt_req       (halt_req),
      .seq_adv        (load),
      .evt            (evt),
      .pc_next        (pc_nxt),
      .misalign       (misalign)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         BOOT, FLUSH: state_nxt = RUN;
         HALT:        if (!halt_req) state_nxt = RUN;
         default:     ;
      endcase
      unique case (evt)
         EV_EXC, EV_ERET, EV_REDIR: state_nxt = FLUSH;
         // Halt waits until a pending IR has been handed over.
         EV_HALT: if (ir_free) state_nxt = HALT;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         ir        <= '0;
         ir_pc     <= '0;
         ir_valid  <= 1'b0;
         epc       <= '0;
         fetch_err <= 1'b0;
         busy_exc  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_nxt;
         pc        <= pc_nxt;
         fetch_err <= misalign;
         unique case (evt)
            EV_EXC: begin
               epc      <= misalign ? redirect_pc : (ir_valid ? ir_pc : pc);
               busy_exc <= 1'b1;
               ir_valid <= 1'b0;
            end
            EV_ERET: begin
               busy_exc <= 1'b0;
               ir_valid <= 1'b0;
            end
            EV_REDIR: ir_valid <= 1'b0;
            EV_HALT:  if (ir_free) ir_valid <= 1'b0;
            default: begin
               if (load) begin
                  ir       <= im_dout;
                  ir_pc    <= pc;
                  ir_valid <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
